// File: rtl/svn_seg_counter_if.sv
// Display pin bundle for the two-digit seven-segment driver.
// master drives the active-low segments and digit enables; slave observes them.
interface svn_seg_counter_if;
  logic [7:0] display_o;
  logic [1:0] seg_sel_o;

  modport master (
    output display_o,
    output seg_sel_o
  );

  modport slave (
    input display_o,
    input seg_sel_o
  );
endinterface

// File: rtl/svn_seg_counter.sv
// Free-running 8-bit hex counter shown on a multiplexed common-anode display.
// Outputs are registered from the pre-edge count/digit state (1-cycle lag); no backpressure.
module svn_seg_counter #(
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  svn_seg_counter_if.master         disp_if
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);

  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          dsel_q, dsel_d;
  logic [7:0]    display_q, display_d;
  logic [1:0]    seg_sel_q, seg_sel_d;

  logic          count_tick;
  logic          scan_tick;
  logic [3:0]    digit;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign count_tick = (tick_q == TW'(TICK_DIV - 1));
  assign scan_tick  = (scan_q == SW'(SCAN_DIV - 1));

  always_comb begin
    tick_d = count_tick ? '0 : tick_q + TW'(1);
    scan_d = scan_tick  ? '0 : scan_q + SW'(1);
    cnt_d  = count_tick ? cnt_q + 8'd1 : cnt_q;
    dsel_d = scan_tick  ? ~dsel_q : dsel_q;

    // Outputs are built from the current (pre-edge) state so digit enable and
    // segment pattern always switch together one cycle after the state change.
    digit     = dsel_q ? cnt_q[7:4] : cnt_q[3:0];
    display_d = hex_to_seg(digit);
    seg_sel_d = dsel_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      tick_q    <= '0;
      scan_q    <= '0;
      cnt_q     <= 8'h00;
      dsel_q    <= 1'b0;
      display_q <= 8'hC0;
      seg_sel_q <= 2'b10;
    end else begin
      tick_q    <= tick_d;
      scan_q    <= scan_d;
      cnt_q     <= cnt_d;
      dsel_q    <= dsel_d;
      display_q <= display_d;
      seg_sel_q <= seg_sel_d;
    end
  end

  assign disp_if.display_o = display_q;
  assign disp_if.seg_sel_o = seg_sel_q;

endmodule

// File: tb/tb_svn_seg_counter.sv
// Four differently-parameterised counters share clock and reset; a scoreboard
// compares every cycle against counts derived from elapsed cycles since reset.
module tb_svn_seg_counter;

  localparam int NDUT = 4;
  localparam int TD [NDUT] = '{4, 1000, 2, 4};
  localparam int SD [NDUT] = '{1000, 3, 2, 4};
  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct packed {
    logic [NDUT-1:0][7:0] disp;
    logic [NDUT-1:0][1:0] sel;
  } exp_t;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  int   k;
  bit   started;
  exp_t exp_q[$];

  logic [7:0] act_disp [NDUT];
  logic [1:0] act_sel  [NDUT];

  svn_seg_counter_if if_a();
  svn_seg_counter_if if_b();
  svn_seg_counter_if if_c();
  svn_seg_counter_if if_d();

  svn_seg_counter #(.TICK_DIV(4),    .SCAN_DIV(1000)) u_a (.clk_i(clk), .rstn_i(rstn), .disp_if(if_a.master));
  svn_seg_counter #(.TICK_DIV(1000), .SCAN_DIV(3))    u_b (.clk_i(clk), .rstn_i(rstn), .disp_if(if_b.master));
  svn_seg_counter #(.TICK_DIV(2),    .SCAN_DIV(2))    u_c (.clk_i(clk), .rstn_i(rstn), .disp_if(if_c.master));
  svn_seg_counter #(.TICK_DIV(4),    .SCAN_DIV(4))    u_d (.clk_i(clk), .rstn_i(rstn), .disp_if(if_d.master));

  assign act_disp[0] = if_a.display_o;
  assign act_disp[1] = if_b.display_o;
  assign act_disp[2] = if_c.display_o;
  assign act_disp[3] = if_d.display_o;
  assign act_sel[0]  = if_a.seg_sel_o;
  assign act_sel[1]  = if_b.seg_sel_o;
  assign act_sel[2]  = if_c.seg_sel_o;
  assign act_sel[3]  = if_d.seg_sel_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display seen after n running cycles: the count is n/TICK_DIV, the digit is n/SCAN_DIV.
  function automatic logic [9:0] model(input int td, input int sd, input int n);
    int         cnt;
    int         dsel;
    logic [7:0] c8;
    logic [3:0] dig;
    cnt  = (n / td) % 256;
    dsel = (n / sd) % 2;
    c8   = 8'(cnt);
    dig  = (dsel != 0) ? c8[7:4] : c8[3:0];
    return {SEG_TAB[dig], (dsel != 0) ? 2'b01 : 2'b10};
  endfunction

  task automatic step(input logic r);
    exp_t       e;
    logic [9:0] m;
    @(negedge clk);
    rstn = r;
    if (!r) begin
      started = 1'b1;
      k = 0;
    end
    if (started) begin
      for (int i = 0; i < NDUT; i++) begin
        m = model(TD[i], SD[i], r ? k : 0);
        e.disp[i] = m[9:2];
        e.sel[i]  = m[1:0];
      end
      exp_q.push_back(e);
      if (r) k++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NDUT; i++) begin
          total++;
          if (act_disp[i] !== e.disp[i]) begin
            bad++;
            $display("FAIL display dut%0d t=%0t got=%h want=%h", i, $time, act_disp[i], e.disp[i]);
          end
          total++;
          if (act_sel[i] !== e.sel[i]) begin
            bad++;
            $display("FAIL seg_sel dut%0d t=%0t got=%b want=%b", i, $time, act_sel[i], e.sel[i]);
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    total   = 0;
    bad     = 0;
    k       = 0;
    started = 1'b0;
    rstn    = 1'b1;
    repeat (5) step(1'b1);
    repeat (5) step(1'b0);
    // Dut a sits at cnt=8'h5A with its prescaler at TICK_DIV-1 after 363 cycles,
    // so this one-cycle reset lands on a count tick.
    repeat (363) step(1'b1);
    step(1'b0);
    // Long enough for the TICK_DIV=2 counter to pass 8'hFF and wrap to 8'h00.
    repeat (700) step(1'b1);
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(200, 1);
      repeat (n) step(1'b1);
      n = $urandom_range(3, 1);
      repeat (n) step(1'b0);
    end
    repeat (50) step(1'b1);
    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
